// File: rtl/bp_seq_pkg.sv
// Shared opcodes, FSM state encoding and result constants for the Bus Pirate
// command sequencer.
package bp_seq_pkg;

  localparam logic [3:0] OP_NOP       = 4'h0;
  localparam logic [3:0] OP_PIN_WRITE = 4'h1;
  localparam logic [3:0] OP_PIN_DIR   = 4'h2;
  localparam logic [3:0] OP_PIN_READ  = 4'h3;
  localparam logic [3:0] OP_DELAY     = 4'h4;
  localparam logic [3:0] OP_XFER      = 4'h5;
  localparam logic [3:0] OP_XFER_WO   = 4'h6;
  localparam logic [3:0] OP_STATUS    = 4'h7;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_EXEC      = 3'd1,
    ST_DELAY     = 3'd2,
    ST_XFER_WAIT = 3'd3,
    ST_PUSH      = 3'd4
  } seq_state_e;

  localparam logic [15:0] TIMEOUT_RESULT = 16'hFFFF;

endpackage

// File: rtl/seq_delay_timer.sv
// Load/decrement down-counter with a zero flag; saturates at zero instead of
// wrapping. Serves both the DELAY opcode and the transfer watchdog.
module seq_delay_timer #(
  parameter int WIDTH = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/bp_cmd_sequencer.sv
// Pops 16-bit command words, drives pins / delays / byte engine in order and
// pushes read results. Define CMD_SEQ_TIMEOUT_EN to add the transfer watchdog.
module bp_cmd_sequencer #(
  parameter int BP_PINS        = 5,
  parameter int FIFO_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_nempty,
  input  logic [FIFO_WIDTH-1:0] in_data,
  output logic                  in_pop,
  input  logic                  out_full,
  output logic                  out_shift,
  output logic [FIFO_WIDTH-1:0] out_data,
  output logic [BP_PINS-1:0]    pins_out,
  output logic [BP_PINS-1:0]    pins_dir,
  input  logic [BP_PINS-1:0]    pins_in,
  output logic                  xfer_start,
  output logic [7:0]            xfer_tx,
  input  logic                  xfer_done,
  input  logic [7:0]            xfer_rx,
  output logic                  busy,
  output logic                  error
);
  import bp_seq_pkg::*;

  seq_state_e            state_q;
  logic [FIFO_WIDTH-1:0] cmd_q;
  logic [FIFO_WIDTH-1:0] out_data_q;
  logic [BP_PINS-1:0]    pins_out_q;
  logic [BP_PINS-1:0]    pins_dir_q;
  logic [7:0]            xfer_tx_q;
  logic                  xfer_start_q;
  logic                  error_q;

  logic [3:0]  op;
  logic [3:0]  in_op;
  logic [11:0] operand;
  logic        timer_load;
  logic        timer_dec;
  logic        timer_zero;
  logic [11:0] timer_val;

  assign op      = cmd_q[15:12];
  assign operand = cmd_q[11:0];
  assign in_op   = in_data[15:12];

  // Handshakes are combinational so a show-ahead FIFO word is consumed in the same cycle.
  assign in_pop    = reset && (state_q == ST_FETCH) && in_nempty;
  assign out_shift = reset && (state_q == ST_PUSH) && !out_full;
  assign busy      = (state_q != ST_FETCH);

  assign out_data   = out_data_q;
  assign pins_out   = pins_out_q;
  assign pins_dir   = pins_dir_q;
  assign xfer_tx    = xfer_tx_q;
  assign xfer_start = xfer_start_q;
  assign error      = error_q;

  // One counter: DELAY loads operand-1, transfers load the watchdog limit.
  always_comb begin
    timer_val  = (op == OP_DELAY) ? (operand - 12'd1) : 12'(TIMEOUT_CYCLES - 1);
    timer_load = (state_q == ST_EXEC) && (op == OP_DELAY) && (operand != 12'd0);
    timer_dec  = (state_q == ST_DELAY);
`ifdef CMD_SEQ_TIMEOUT_EN
    if ((state_q == ST_EXEC) && ((op == OP_XFER) || (op == OP_XFER_WO))) begin
      timer_load = 1'b1;
    end
    if (state_q == ST_XFER_WAIT) begin
      timer_dec = 1'b1;
    end
`endif
  end

  seq_delay_timer #(.WIDTH(12)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .dec_i      (timer_dec),
    .zero_o     (timer_zero)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_FETCH;
      cmd_q        <= '0;
      out_data_q   <= '0;
      pins_out_q   <= '0;
      pins_dir_q   <= '1;
      xfer_tx_q    <= '0;
      xfer_start_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      xfer_start_q <= 1'b0;
      case (state_q)
        ST_FETCH: begin
          if (in_nempty) begin
            cmd_q   <= in_data;
            state_q <= ST_EXEC;
            if ((in_op == OP_XFER) || (in_op == OP_XFER_WO)) begin
              xfer_tx_q    <= in_data[7:0];
              xfer_start_q <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          state_q <= ST_FETCH;
          case (op)
            OP_NOP:       ;
            OP_PIN_WRITE: pins_out_q <= cmd_q[BP_PINS-1:0];
            OP_PIN_DIR:   pins_dir_q <= cmd_q[BP_PINS-1:0];
            OP_PIN_READ: begin
              out_data_q <= {{(FIFO_WIDTH-BP_PINS){1'b0}}, pins_in};
              state_q    <= ST_PUSH;
            end
            OP_DELAY: begin
              if (operand != 12'd0) state_q <= ST_DELAY;
            end
            OP_XFER, OP_XFER_WO: state_q <= ST_XFER_WAIT;
            OP_STATUS: begin
              out_data_q <= {{(FIFO_WIDTH-1){1'b0}}, error_q};
              error_q    <= 1'b0;
              state_q    <= ST_PUSH;
            end
            default: error_q <= 1'b1;
          endcase
        end
        ST_DELAY: begin
          if (timer_zero) state_q <= ST_FETCH;
        end
        ST_XFER_WAIT: begin
          if (xfer_done) begin
            if (op == OP_XFER) begin
              out_data_q <= {{(FIFO_WIDTH-8){1'b0}}, xfer_rx};
              state_q    <= ST_PUSH;
            end else begin
              state_q <= ST_FETCH;
            end
          end
`ifdef CMD_SEQ_TIMEOUT_EN
          else if (timer_zero) begin
            error_q <= 1'b1;
            if (op == OP_XFER) begin
              out_data_q <= TIMEOUT_RESULT;
              state_q    <= ST_PUSH;
            end else begin
              state_q <= ST_FETCH;
            end
          end
`endif
        end
        ST_PUSH: begin
          if (!out_full) state_q <= ST_FETCH;
        end
        default: state_q <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_cmd_sequencer.sv
// Directed bench for bp_cmd_sequencer: FIFO and byte-engine models, scoreboard
// of expected result words, timing checks on pop spacing.
module tb_bp_cmd_sequencer;

  localparam int TIMEOUT_CYCLES = 255;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_nempty;
  logic [15:0] in_data;
  logic        in_pop;
  logic        out_full;
  logic        out_shift;
  logic [15:0] out_data;
  logic [4:0]  pins_out;
  logic [4:0]  pins_dir;
  logic [4:0]  pins_in;
  logic        xfer_start;
  logic [7:0]  xfer_tx;
  logic        xfer_done;
  logic [7:0]  xfer_rx;
  logic        busy;
  logic        error;

  bp_cmd_sequencer #(.BP_PINS(5), .FIFO_WIDTH(16), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_nempty  (in_nempty),
    .in_data    (in_data),
    .in_pop     (in_pop),
    .out_full   (out_full),
    .out_shift  (out_shift),
    .out_data   (out_data),
    .pins_out   (pins_out),
    .pins_dir   (pins_dir),
    .pins_in    (pins_in),
    .xfer_start (xfer_start),
    .xfer_tx    (xfer_tx),
    .xfer_done  (xfer_done),
    .xfer_rx    (xfer_rx),
    .busy       (busy),
    .error      (error)
  );

  always #5 clock = ~clock;

  logic [15:0] fifo_q[$];
  logic [15:0] sb_q[$];
  int          pop_cyc[$];
  int          cyc = 0;
  int          last_shift_cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  bit          pop_seen = 1'b0;
  bit          start_seen = 1'b0;
  bit          xfer_auto = 1'b1;
  int          xfer_cnt = 0;
  logic [7:0]  model_rx = 8'h00;
  logic [7:0]  exp_tx = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observe DUT on the falling edge: handshakes, start byte, scoreboard.
  always @(negedge clock) begin
    pop_seen   = in_pop;
    start_seen = xfer_start;
    if (in_pop) pop_cyc.push_back(cyc);
    if (xfer_start) check("xfer_tx", {24'h0, xfer_tx}, {24'h0, exp_tx});
    if (out_shift) begin
      last_shift_cyc = cyc;
      check("push_expected", {31'h0, sb_q.size() > 0}, 32'h1);
      if (sb_q.size() > 0) begin
        logic [15:0] e;
        e = sb_q.pop_front();
        check("out_data", {16'h0, out_data}, {16'h0, e});
        $display("push: out_data=%04h expected=%04h at cycle %0d", out_data, e, cyc);
      end
    end
  end

  // FIFO head and byte-engine models update just after the rising edge.
  always @(posedge clock) begin
    cyc++;
    #1;
    if (pop_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
    xfer_done = 1'b0;
    if (start_seen && xfer_auto) begin
      xfer_cnt = 10;
    end else if (xfer_cnt > 0) begin
      xfer_cnt--;
      if (xfer_cnt == 0) begin
        xfer_done = 1'b1;
        xfer_rx   = model_rx;
      end
    end
    in_nempty = (fifo_q.size() > 0);
    in_data   = (fifo_q.size() > 0) ? fifo_q[0] : 16'h0000;
  end

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while ((fifo_q.size() != 0 || in_nempty || busy) && n < budget);
    check({tag, "_idle"}, {31'h0, n < budget}, 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    bit got_done;
    reset = 1'b0; out_full = 1'b0; pins_in = 5'b01010;
    xfer_done = 1'b0; xfer_rx = 8'h00; in_nempty = 1'b0; in_data = 16'h0;
    fifo_q = '{16'h1015, 16'h0000, 16'h0000};

    // Reset with a non-empty FIFO
    repeat (3) begin
      @(negedge clock);
      check("rst_in_pop", {31'h0, in_pop}, 32'h0);
    end
    check("rst_pins_dir", {27'h0, pins_dir}, 32'h1F);
    check("rst_pins_out", {27'h0, pins_out}, 32'h0);
    check("rst_error", {31'h0, error}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_out_data", {16'h0, out_data}, 32'h0);
    $display("reset: pins_dir=%05b pins_out=%05b error=%0b", pins_dir, pins_out, error);
    @(posedge clock); #1 reset = 1'b1;
    wait_idle("post_reset", 50);

    // Pin write / direction / read
    sb_q.push_back(16'h000A);
    fifo_q.push_back(16'h1015); fifo_q.push_back(16'h2000); fifo_q.push_back(16'h3000);
    wait_idle("pins", 50);
    check("pins_out", {27'h0, pins_out}, 32'h15);
    check("pins_dir", {27'h0, pins_dir}, 32'h00);
    $display("pins: pins_out=%05b pins_dir=%05b", pins_out, pins_dir);

    // DELAY 5: next pop 7 cycles after the first
    pop_cyc.delete();
    fifo_q.push_back(16'h4005); fifo_q.push_back(16'h0000);
    wait_idle("delay5", 50);
    check("delay5_pops", pop_cyc.size(), 2);
    check("delay5_gap", (pop_cyc.size() == 2) ? pop_cyc[1] - pop_cyc[0] : -1, 7);
    $display("delay5: pops=%0d", pop_cyc.size());

    // DELAY 0 behaves like NOP: back-to-back commands every 2 cycles
    pop_cyc.delete();
    fifo_q.push_back(16'h4000); fifo_q.push_back(16'h0000);
    wait_idle("delay0", 50);
    check("delay0_gap", (pop_cyc.size() == 2) ? pop_cyc[1] - pop_cyc[0] : -1, 2);
    $display("delay0: pops=%0d", pop_cyc.size());

    // Maximum delay 0xFFF
    pop_cyc.delete();
    fifo_q.push_back(16'h4FFF); fifo_q.push_back(16'h0000);
    wait_idle("delay_max", 5000);
    check("delay_max_gap", (pop_cyc.size() == 2) ? pop_cyc[1] - pop_cyc[0] : -1, 4097);
    $display("delay_max: pops=%0d", pop_cyc.size());

    // XFER with output FIFO back-pressure
    out_full = 1'b1; exp_tx = 8'hA5; model_rx = 8'h3C;
    sb_q.push_back(16'h003C);
    fifo_q.push_back(16'h50A5);
    got_done = 1'b0;
    for (int i = 0; i < 60 && !got_done; i++) begin
      @(negedge clock);
      if (xfer_done) got_done = 1'b1;
    end
    check("xfer_done_seen", {31'h0, got_done}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("full_no_shift", {31'h0, out_shift}, 32'h0);
      check("full_hold_data", {16'h0, out_data}, 32'h003C);
    end
    @(posedge clock); #1 out_full = 1'b0;
    wait_idle("xfer", 50);
    $display("xfer: rx=%02h out_data=%04h", model_rx, out_data);

    // Write-only transfer pushes nothing
    exp_tx = 8'h33; model_rx = 8'h77;
    fifo_q.push_back(16'h6033);
    wait_idle("xfer_wo", 50);
    $display("xfer_wo: tx=%02h", exp_tx);

    // Illegal opcode sets error; STATUS reports then clears it
    fifo_q.push_back(16'h9000);
    wait_idle("illegal", 50);
    check("illegal_error", {31'h0, error}, 32'h1);
    sb_q.push_back(16'h0001); sb_q.push_back(16'h0000);
    fifo_q.push_back(16'h7000); fifo_q.push_back(16'h7000);
    wait_idle("status", 50);
    check("status_cleared", {31'h0, error}, 32'h0);
    $display("status: error=%0b", error);

`ifdef CMD_SEQ_TIMEOUT_EN
    // Watchdog: no xfer_done ever arrives
    xfer_auto = 1'b0; exp_tx = 8'h11;
    pop_cyc.delete();
    sb_q.push_back(16'hFFFF);
    fifo_q.push_back(16'h5011);
    wait_idle("timeout", 600);
    check("timeout_error", {31'h0, error}, 32'h1);
    check("timeout_latency", (pop_cyc.size() == 1) ? last_shift_cyc - pop_cyc[0] : -1, TIMEOUT_CYCLES + 2);
    xfer_auto = 1'b1;
    sb_q.push_back(16'h000A); sb_q.push_back(16'h0001);
    fifo_q.push_back(16'h3000); fifo_q.push_back(16'h7000);
    wait_idle("after_timeout", 50);
    $display("timeout: error cleared=%0b", !error);
`endif

    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
